vga_pattern_scheduler: RTL and testbench
========================================

Name: vga_pattern_scheduler

Overview:
- Selects and sequences the active VGA test pattern, and generates the registered 24-bit pixel colour for the DAC.
- Sits between vga_sync (provides x, y, video_on, pixel tick, frame start) and the board rgb/blank outputs.
- Pattern changes come from a manual request pulse, or automatically after a programmable number of frames.
- A pattern only ever changes at a frame boundary, so no frame is torn.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- CELL_LOG2, 5, checkerboard cell size is 2**CELL_LOG2 pixels
- DWELL_W, 8, width of the frame dwell counter/config

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_tick  in  1  pixel enable from vga_sync; all state advances only when high
- frame_start  in  1  one-tick pulse, qualified by pix_tick, at x=0,y=0 of each frame
- video_on  in  1  visible-area flag from vga_sync
- x  in  10  current pixel column
- y  in  10  current pixel row
- next_req  in  1  single-cycle request to advance to the next pattern
- auto_en  in  1  1 = auto-cycle mode, 0 = hold mode
- dwell_frames  in  DWELL_W  frames per pattern in auto mode; 0 is treated as 1
- solid_color  in  24  colour used by the solid pattern
- rgb  out  24  registered pixel colour; 0 outside the visible area
- blank_n  out  1  registered video_on, aligned with rgb
- pattern_id  out  2  currently displayed pattern
- switch_pulse  out  1  one pix_tick-qualified cycle, high on the tick a new pattern takes effect

Behaviour:
- Reset (clk edge with reset=1): rgb=0, blank_n=0, pattern_id=0, switch_pulse=0, pending=0, dwell_cnt=0, state=HOLD.
- Reset mid-frame takes effect on the next edge. The displayed pattern is 0 from the first post-reset pix_tick.
- Patterns, selected by pattern_id:
  - 0 checkerboard: white (FFFFFF) if x[CELL_LOG2]^y[CELL_LOG2], else black.
  - 1 colour bars: bar index = x/80 (8 bars, clamped to 7). Colours in order: white, yellow, cyan, green, magenta, red, blue, black (RGB888 full-scale).
  - 2 gradient: R=x[9:2], G=y[8:1], B=8'h80.
  - 3 solid: solid_color.
- Latency: rgb/blank_n are exactly 1 pix_tick after the x/y/video_on sample. Outside video_on, rgb=0.
- next_req is latched into a sticky pending flag on any clk cycle; it does not need pix_tick. Multiple requests within one frame collapse to one advance.
- FSM, two states:
  - HOLD: advance only if pending.
  - AUTO: dwell_cnt increments on each frame_start. Advance when dwell_cnt reaches max(dwell_frames,1)-1, or when pending.
  - auto_en is sampled on frame_start: HOLD->AUTO when auto_en=1, AUTO->HOLD when auto_en=0. dwell_cnt clears on each mode change.
- Advance happens only on a pix_tick with frame_start=1:
  - pattern_id <= pattern_id+1 (wraps 3->0).
  - pending clears.
  - dwell_cnt clears.
  - switch_pulse=1 for that tick.
- The new pattern is used for pixel (0,0) of that frame, so rgb reflects it at the next pix_tick.
- Simultaneous dwell expiry and pending on the same frame_start: advance by one only; both conditions are cleared.
- next_req arriving on the same cycle as an advancing frame_start is consumed by that advance and does not set pending.
- dwell_frames changing mid-count: the new value is compared immediately. If dwell_cnt is already >= the new limit, advance at the next frame_start.
- pix_tick=0: all registers hold, except pending capture.

Optional Feature:
- Macro: VGA_PATTERN_BORDER_EN.
- Defined: a 1-pixel white (FFFFFF) border overrides every pattern at x==0, x==H_ACTIVE-1, y==0 and y==V_ACTIVE-1, inside video_on. Latency is unchanged.
- Undefined: no border logic; patterns are drawn edge to edge.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE/V_ACTIVE constants
  - pattern_id encodings (PAT_CHECKER=0, PAT_BARS=1, PAT_GRAD=2, PAT_SOLID=3)
  - the 8 colour-bar RGB constants
  - FSM state encoding (ST_HOLD, ST_AUTO)
- One natural sub-module: vga_pattern_gen. It is purely combinational: pattern_id, x, y, solid_color -> pixel colour. It is instantiated once; the scheduler owns the FSM, counters and the output register.

Test Plan:
- Reset asserted mid-frame with pattern_id=2 -> next edge gives rgb=0, blank_n=0, pattern_id=0. First visible pixel (x=32,y=0) after release gives rgb=FFFFFF.
- HOLD mode, next_req pulsed 3 times mid-frame -> exactly one advance (0->1) at the next frame_start, switch_pulse high for one tick, pixel x=85 gives FFFF00.
- AUTO mode, dwell_frames=2 -> pattern_id sequence 0,0,1,1,2,2,3,3,0 over 9 frames (wrap checked). dwell_frames=0 -> changes every frame.
- AUTO mode with next_req in the frame where the dwell expires -> single advance only, dwell restarts from 0.
- Pattern 2 at x=400,y=100 -> rgb=64_32_80 one pix_tick later. Same x,y with video_on=0 -> rgb=0. pix_tick held low -> rgb stable.
- With VGA_PATTERN_BORDER_EN, pattern 3 and solid_color=123456 -> x=639 gives FFFFFF, x=638,y=1 gives 123456. Without the macro, x=639 gives 123456.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern scheduler: display size, pattern
// encodings, colour-bar palette and scheduler FSM states.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned RGB_W    = 24;

  typedef enum logic [1:0] {
    PAT_CHECKER = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_GRAD    = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
  localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_AUTO = 1'b1
  } state_e;

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern colour generator.
// Optional white frame border when VGA_PATTERN_BORDER_EN is defined.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned CELL_LOG2 = 5
) (
  input  logic [1:0]  pattern_sel,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [23:0] solid_color,
  output logic [23:0] pixel_c
);
  import vga_pkg::*;

  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [9:0] bar_q;
  logic [2:0] bar_idx;
  logic       chk_bit;
  logic       on_border;

`ifdef VGA_PATTERN_BORDER_EN
  assign on_border = (x == 10'd0) || (x == 10'(H_ACTIVE - 1)) ||
                     (y == 10'd0) || (y == 10'(V_ACTIVE - 1));
`else
  assign on_border = 1'b0;
`endif

  always_comb begin
    bar_q   = x / 10'(BAR_W);
    bar_idx = (bar_q > 10'd7) ? 3'd7 : bar_q[2:0];
    chk_bit = 1'((x ^ y) >> CELL_LOG2);
    pixel_c = '0;
    case (pattern_sel)
      PAT_CHECKER: pixel_c = chk_bit ? BAR_WHITE : BAR_BLACK;
      PAT_BARS:    pixel_c = bar_color(bar_idx);
      PAT_GRAD:    pixel_c = {x[9:2], y[8:1], 8'h80};
      default:     pixel_c = solid_color;
    endcase
    if (on_border) pixel_c = BAR_WHITE;
  end

endmodule

// File: rtl/vga_pattern_scheduler.sv
// VGA test-pattern sequencer: HOLD/AUTO mode FSM, frame-aligned pattern
// switching and registered pixel output. Border option: VGA_PATTERN_BORDER_EN.
module vga_pattern_scheduler #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned CELL_LOG2 = 5,
  parameter int unsigned DWELL_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_tick,
  input  logic               frame_start,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               next_req,
  input  logic               auto_en,
  input  logic [DWELL_W-1:0] dwell_frames,
  input  logic [23:0]        solid_color,
  output logic [23:0]        rgb,
  output logic               blank_n,
  output logic [1:0]         pattern_id,
  output logic               switch_pulse
);
  import vga_pkg::*;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] limit_c;
  logic               pending_q, pending_d;
  logic               expired_c;
  logic               advance_c;
  logic [1:0]         pat_d;
  logic [23:0]        pixel_c;

  // Next-pattern drives the generator so pixel (0,0) of a new frame uses it.
  vga_pattern_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .CELL_LOG2 (CELL_LOG2)
  ) u_gen (
    .pattern_sel (pat_d),
    .x           (x),
    .y           (y),
    .solid_color (solid_color),
    .pixel_c     (pixel_c)
  );

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    pat_d     = pattern_id;
    pending_d = pending_q | next_req;
    advance_c = 1'b0;
    limit_c   = (dwell_frames == '0) ? '0 : dwell_frames - DWELL_W'(1);
    // >= so a dwell limit lowered mid-count still expires at the next frame
    expired_c = (dwell_q >= limit_c);

    if (pix_tick && frame_start) begin
      unique case (state_q)
        ST_HOLD: begin
          advance_c = pending_q;
          if (auto_en) state_d = ST_AUTO;
        end
        ST_AUTO: begin
          advance_c = pending_q | expired_c;
          if (!auto_en) state_d = ST_HOLD;
        end
      endcase

      if (advance_c || (state_d != state_q)) begin
        dwell_d = '0;
      end else if (state_q == ST_AUTO) begin
        dwell_d = dwell_q + DWELL_W'(1);
      end

      if (advance_c) begin
        pat_d     = pattern_id + 2'd1;
        pending_d = 1'b0;
      end
    end
  end

  // Request capture runs every clock; everything else advances on pix_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      dwell_q      <= '0;
      pending_q    <= 1'b0;
      pattern_id   <= 2'd0;
      rgb          <= '0;
      blank_n      <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      switch_pulse <= advance_c;
      if (pix_tick) begin
        state_q    <= state_d;
        dwell_q    <= dwell_d;
        pattern_id <= pat_d;
        rgb        <= video_on ? pixel_c : 24'h000000;
        blank_n    <= video_on;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Self-checking bench for vga_pattern_scheduler: vector table, directed
// scheduling sequences and randomized pixels against a reference model.
module tb_vga_pattern_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_tick, frame_start, video_on, next_req, auto_en;
  logic [9:0]  x, y;
  logic [7:0]  dwell_frames;
  logic [23:0] solid_color;
  logic [23:0] rgb;
  logic        blank_n;
  logic [1:0]  pattern_id;
  logic        switch_pulse;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_pattern_scheduler #(
    .H_ACTIVE (640), .V_ACTIVE (480), .CELL_LOG2 (5), .DWELL_W (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_tick     (pix_tick),
    .frame_start  (frame_start),
    .video_on     (video_on),
    .x            (x),
    .y            (y),
    .next_req     (next_req),
    .auto_en      (auto_en),
    .dwell_frames (dwell_frames),
    .solid_color  (solid_color),
    .rgb          (rgb),
    .blank_n      (blank_n),
    .pattern_id   (pattern_id),
    .switch_pulse (switch_pulse)
  );

`ifdef VGA_PATTERN_BORDER_EN
  localparam logic [23:0] EDGE_SOLID = 24'hFFFFFF;
  localparam logic [23:0] EDGE_BAR7  = 24'hFFFFFF;
  localparam bit          BORDER     = 1'b1;
`else
  localparam logic [23:0] EDGE_SOLID = 24'h123456;
  localparam logic [23:0] EDGE_BAR7  = 24'h000000;
  localparam bit          BORDER     = 1'b0;
`endif

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct {
    logic [1:0]  pat;
    logic [9:0]  vx;
    logic [9:0]  vy;
    logic        vo;
    logic [23:0] solid;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs [14];

  // Reference pixel colour from the pattern rules, in plain arithmetic.
  function automatic logic [23:0] model_pix(input int pat, input int xx, input int yy,
                                            input logic [23:0] solid);
    int bar;
    if (BORDER && (xx == 0 || xx == 639 || yy == 0 || yy == 479)) return 24'hFFFFFF;
    case (pat)
      0: return ((((xx / 32) + (yy / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      1: begin
        bar = xx / 80;
        if (bar > 7) bar = 7;
        return BARS[bar];
      end
      2: return {8'((xx / 4) % 256), 8'((yy / 2) % 256), 8'h80};
      default: return solid;
    endcase
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic pt, input logic fs, input logic vo,
                      input logic [9:0] xx, input logic [9:0] yy, input logic nr);
    pix_tick    = pt;
    frame_start = fs;
    video_on    = vo;
    x           = xx;
    y           = yy;
    next_req    = nr;
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pattern(input logic [1:0] p);
    for (int i = 0; i < 4; i++) begin
      if (pattern_id == p) break;
      step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    end
    chk("goto_pattern", 24'(pattern_id), 24'(p));
  endtask

  initial begin
    int exp_pat;
    int xi, yi, pat;
    logic pt, vo;
    logic [23:0] exp_rgb;
    logic exp_blank;

    vecs[0]  = '{2'd0, 10'd32,  10'd0,   1'b1, 24'h000000, 24'hFFFFFF};
    vecs[1]  = '{2'd0, 10'd32,  10'd32,  1'b1, 24'h000000, 24'h000000};
    vecs[2]  = '{2'd0, 10'd64,  10'd32,  1'b1, 24'h000000, 24'hFFFFFF};
    vecs[3]  = '{2'd1, 10'd85,  10'd10,  1'b1, 24'h000000, 24'hFFFF00};
    vecs[4]  = '{2'd1, 10'd200, 10'd10,  1'b1, 24'h000000, 24'h00FFFF};
    vecs[5]  = '{2'd1, 10'd320, 10'd10,  1'b1, 24'h000000, 24'hFF00FF};
    vecs[6]  = '{2'd1, 10'd500, 10'd10,  1'b1, 24'h000000, 24'h0000FF};
    vecs[7]  = '{2'd1, 10'd639, 10'd10,  1'b1, 24'h000000, EDGE_BAR7};
    vecs[8]  = '{2'd2, 10'd400, 10'd100, 1'b1, 24'h000000, 24'h643280};
    vecs[9]  = '{2'd2, 10'd400, 10'd100, 1'b0, 24'h000000, 24'h000000};
    vecs[10] = '{2'd2, 10'd3,   10'd7,   1'b1, 24'h000000, 24'h000380};
    vecs[11] = '{2'd3, 10'd639, 10'd100, 1'b1, 24'h123456, EDGE_SOLID};
    vecs[12] = '{2'd3, 10'd638, 10'd1,   1'b1, 24'h123456, 24'h123456};
    vecs[13] = '{2'd3, 10'd0,   10'd479, 1'b1, 24'h123456, EDGE_SOLID};

    reset = 1'b1; auto_en = 1'b0; dwell_frames = 8'd0; solid_color = 24'h123456;
    step(1'b1, 1'b0, 1'b1, 10'd40, 10'd40, 1'b0);
    step(1'b1, 1'b0, 1'b1, 10'd40, 10'd40, 1'b0);
    chk("reset_rgb", rgb, 24'h0);
    chk("reset_blank", 24'(blank_n), 24'h0);
    chk("reset_pattern", 24'(pattern_id), 24'h0);
    chk("reset_switch", 24'(switch_pulse), 24'h0);
    reset = 1'b0;

    // Three requests in one frame collapse to a single advance.
    step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    chk("hold_no_req", 24'(pattern_id), 24'd0);
    step(1'b1, 1'b0, 1'b1, 10'd10, 10'd5, 1'b1);
    step(1'b0, 1'b0, 1'b1, 10'd11, 10'd5, 1'b1);
    step(1'b1, 1'b0, 1'b1, 10'd11, 10'd5, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd12, 10'd5, 1'b1);
    step(1'b1, 1'b0, 1'b1, 10'd12, 10'd5, 1'b0);
    chk("hold_midframe", 24'(pattern_id), 24'd0);
    step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    chk("hold_advance", 24'(pattern_id), 24'd1);
    chk("hold_switch_hi", 24'(switch_pulse), 24'd1);
    step(1'b1, 1'b0, 1'b1, 10'd85, 10'd5, 1'b0);
    chk("hold_switch_lo", 24'(switch_pulse), 24'd0);
    chk("hold_bar_x85", rgb, 24'hFFFF00);
    step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    chk("hold_collapse", 24'(pattern_id), 24'd1);

    for (int i = 0; i < 14; i++) begin
      goto_pattern(vecs[i].pat);
      solid_color = vecs[i].solid;
      step(1'b1, 1'b0, vecs[i].vo, vecs[i].vx, vecs[i].vy, 1'b0);
      chk($sformatf("vec%0d_rgb", i), rgb, vecs[i].exp_rgb);
      chk($sformatf("vec%0d_blank", i), 24'(blank_n), 24'(vecs[i].vo));
    end

    // pix_tick low freezes every output, even across a frame_start.
    goto_pattern(2'd2);
    step(1'b1, 1'b0, 1'b1, 10'd400, 10'd100, 1'b0);
    chk("stall_ref", rgb, 24'h643280);
    step(1'b0, 1'b0, 1'b0, 10'd7, 10'd9, 1'b0);
    step(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd100, 10'd3, 1'b0);
    chk("stall_rgb", rgb, 24'h643280);
    chk("stall_blank", 24'(blank_n), 24'd1);
    chk("stall_pattern", 24'(pattern_id), 24'd2);

    // Mid-frame reset with pattern 2 displayed.
    step(1'b1, 1'b0, 1'b1, 10'd400, 10'd100, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1, 10'd401, 10'd100, 1'b0);
    chk("midreset_rgb", rgb, 24'h0);
    chk("midreset_blank", 24'(blank_n), 24'h0);
    chk("midreset_pattern", 24'(pattern_id), 24'h0);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b1, 10'd32, 10'd0, 1'b0);
    chk("post_reset_pixel", rgb, 24'hFFFFFF);

    // Auto mode, two frames per pattern, then one frame per pattern.
    auto_en = 1'b1; dwell_frames = 8'd2;
    for (int f = 0; f < 9; f++) begin
      step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
      exp_pat = (f / 2) % 4;
      chk($sformatf("auto2_f%0d", f), 24'(pattern_id), 24'(exp_pat));
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 10'(k + 50), 10'd20, 1'b0);
    end
    dwell_frames = 8'd0;
    exp_pat = 0;
    for (int f = 0; f < 4; f++) begin
      step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
      exp_pat = (exp_pat + 1) % 4;
      chk($sformatf("auto0_f%0d", f), 24'(pattern_id), 24'(exp_pat));
      step(1'b1, 1'b0, 1'b1, 10'd60, 10'd20, 1'b0);
    end

    // Request in the expiring frame yields a single advance; dwell restarts.
    dwell_frames = 8'd2;
    step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    chk("dual_a_hold", 24'(pattern_id), 24'(exp_pat));
    step(1'b1, 1'b0, 1'b1, 10'd70, 10'd20, 1'b1);
    step(1'b1, 1'b0, 1'b1, 10'd71, 10'd20, 1'b0);
    step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    exp_pat = (exp_pat + 1) % 4;
    chk("dual_b_adv", 24'(pattern_id), 24'(exp_pat));
    chk("dual_b_switch", 24'(switch_pulse), 24'd1);
    step(1'b1, 1'b0, 1'b1, 10'd72, 10'd20, 1'b0);
    step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    chk("dual_c_hold", 24'(pattern_id), 24'(exp_pat));
    step(1'b1, 1'b0, 1'b1, 10'd73, 10'd20, 1'b0);
    step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    exp_pat = (exp_pat + 1) % 4;
    chk("dual_d_adv", 24'(pattern_id), 24'(exp_pat));

    auto_en = 1'b0;
    step(1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
    chk("back_to_hold", 24'(pattern_id), 24'(exp_pat));

    // Random pixels against the reference model, with random pix_tick stalls.
    exp_rgb = rgb;
    exp_blank = blank_n;
    for (int seg = 0; seg < 4; seg++) begin
      pat = int'($urandom_range(0, 3));
      goto_pattern(2'(pat));
      exp_rgb = rgb;
      exp_blank = blank_n;
      for (int n = 0; n < 75; n++) begin
        xi = int'($urandom_range(0, 639));
        yi = int'($urandom_range(0, 479));
        pt = 1'($urandom_range(0, 3) != 0);
        vo = 1'($urandom_range(0, 4) != 0);
        solid_color = 24'($urandom);
        if (pt) begin
          exp_rgb = vo ? model_pix(pat, xi, yi, solid_color) : 24'h0;
          exp_blank = vo;
        end
        step(pt, 1'b0, vo, 10'(xi), 10'(yi), 1'b0);
        chk("rand_rgb", rgb, exp_rgb);
        chk("rand_blank", 24'(blank_n), 24'(exp_blank));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
